// File: rtl/heartbeat_array.sv
// heartbeat_array
//   NCH independent heartbeat channels. Each channel has its own counter,
//   period, duty and output mode (OFF, PULSE, TOGGLE, PWM). Channels are
//   programmed through a valid/ready configuration port. After reset, every
//   channel is in PULSE mode with period all-ones. This gives a one-cycle
//   pulse every 2^N enabled cycles.
//
// Parameters
//   N    counter / period / duty width in bits
//   NCH  number of channels (>= 1)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   en          global count enable shared by all channels
//   cfg_valid   configuration write request
//   cfg_ready   configuration port can accept a write
//   cfg_ch      target channel (indices >= NCH are accepted and ignored)
//   cfg_mode    00 OFF, 01 PULSE, 10 TOGGLE, 11 PWM
//   cfg_period  terminal count; one channel cycle is period+1 enabled clocks
//   cfg_duty    PWM high count
//   out         per-channel registered output
//   wrap        per-channel registered terminal-count strobe
module heartbeat_array #(
  parameter int N   = 8,
  parameter int NCH = 4,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [N-1:0]   cfg_period,
  input  logic [N-1:0]   cfg_duty,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] wrap
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_PWM    = 2'b11
  } mode_t;

  logic          accept;
  logic          wr_vld_p1;
  logic [CW-1:0] wr_ch_p1;
  mode_t         wr_mode_p1;
  logic [N-1:0]  wr_period_p1;
  logic [N-1:0]  wr_duty_p1;

  assign accept = cfg_valid & cfg_ready;

  // ---- stage p1: accepted write is held for one cycle, then applied ----
  // Holding the write for one cycle drops cfg_ready for that cycle. This
  // limits the write rate to one every two cycles. A reset on the apply edge
  // discards the held write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      wr_vld_p1 <= 1'b0;
    end else begin
      cfg_ready <= ~accept;
      wr_vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_ch_p1     <= cfg_ch;
      wr_mode_p1   <= mode_t'(cfg_mode);
      wr_period_p1 <= cfg_period;
      wr_duty_p1   <= cfg_duty;
    end
  end

  // ---- stage p2: per-channel counter and registered outputs ----
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mode_t        mode;
    logic [N-1:0] period;
    logic [N-1:0] duty;
    logic [N-1:0] cnt;
    logic         tog;
    logic         out_q;
    logic         wrap_q;
    logic         load;
    logic         at_term;
    logic         wrap_hit;

    // An out-of-range channel index matches no channel, so that write is dropped.
    assign load     = wr_vld_p1 && (wr_ch_p1 == CW'(i));
    assign at_term  = (cnt == period);
    assign wrap_hit = en && (mode != MODE_OFF) && at_term;

    always_ff @(posedge clk) begin
      if (reset) begin
        mode   <= MODE_PULSE;
        period <= '1;
        duty   <= '0;
        cnt    <= '0;
        tog    <= 1'b0;
        out_q  <= 1'b0;
        wrap_q <= 1'b0;
      end else if (load) begin
        // The clear takes priority over a terminal count on the same edge.
        mode   <= wr_mode_p1;
        period <= wr_period_p1;
        duty   <= wr_duty_p1;
        cnt    <= '0;
        tog    <= 1'b0;
        out_q  <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        wrap_q <= wrap_hit;
        if (mode == MODE_OFF) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= at_term ? '0 : cnt + 1'b1;
        end
        tog <= tog ^ wrap_hit;
        case (mode)
          MODE_OFF:    out_q <= 1'b0;
          MODE_PULSE:  out_q <= wrap_hit;
          MODE_TOGGLE: out_q <= tog ^ wrap_hit;
          // PWM tracks the counter even while en is low. If duty > period,
          // this comparison is always true.
          default:     out_q <= (cnt < duty);
        endcase
      end
    end

    assign out[i]  = out_q;
    assign wrap[i] = wrap_q;
  end

endmodule

// File: tb/tb_heartbeat_array.sv
`timescale 1ns/1ps
module tb_heartbeat_array;
  localparam int N   = 8;
  localparam int NCH = 5;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic [1:0]     cfg_mode;
  logic [N-1:0]   cfg_period;
  logic [N-1:0]   cfg_duty;
  logic [NCH-1:0] out;
  logic [NCH-1:0] wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  heartbeat_array #(.N(N), .NCH(NCH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .out        (out),
    .wrap       (wrap)
  );

  // Behavioural model. Each channel keeps n, the number of enabled cycles
  // since its last clear. The counter value is n mod (period+1). The toggle
  // level is the parity of the completed periods. Writes are applied one
  // edge after they are accepted.
  int             m_mode   [NCH];
  int             m_period [NCH];
  int             m_duty   [NCH];
  int             m_n      [NCH];
  logic [NCH-1:0] m_out;
  logic [NCH-1:0] m_wrap;
  logic           m_ready;
  bit             m_pend;
  int             p_ch, p_mode, p_period, p_duty;
  bit             m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i]   = 1;
        m_period[i] = (1 << N) - 1;
        m_duty[i]   = 0;
        m_n[i]      = 0;
      end
      m_out   = '0;
      m_wrap  = '0;
      m_ready = 1'b0;
      m_pend  = 1'b0;
      m_live  = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m_pend && p_ch == i) begin
          m_mode[i]   = p_mode;
          m_period[i] = p_period;
          m_duty[i]   = p_duty;
          m_n[i]      = 0;
          m_out[i]    = 1'b0;
          m_wrap[i]   = 1'b0;
        end else if (m_mode[i] == 0) begin
          m_n[i]    = 0;
          m_out[i]  = 1'b0;
          m_wrap[i] = 1'b0;
        end else begin
          int c;
          bit w;
          c = m_n[i] % (m_period[i] + 1);
          w = en && (c == m_period[i]);
          m_wrap[i] = w;
          if (en) m_n[i] = m_n[i] + 1;
          case (m_mode[i])
            1:       m_out[i] = w;
            2:       m_out[i] = ((m_n[i] / (m_period[i] + 1)) % 2) == 1;
            default: m_out[i] = (c < m_duty[i]);
          endcase
        end
      end
      if (m_pend) begin
        m_pend  = 1'b0;
        m_ready = 1'b1;
      end else if (cfg_valid && m_ready) begin
        m_pend   = 1'b1;
        p_ch     = int'(cfg_ch);
        p_mode   = int'(cfg_mode);
        p_period = int'(cfg_period);
        p_duty   = int'(cfg_duty);
        m_ready  = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      tests++;
      if (out !== m_out || wrap !== m_wrap || cfg_ready !== m_ready) begin
        fails++;
        $display("FAIL model t=%0t out=%b exp=%b wrap=%b exp=%b ready=%b exp=%b",
                 $time, out, m_out, wrap, m_wrap, cfg_ready, m_ready);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cfg_ready && k < 20) begin
      tick();
      k++;
    end
    check("cfg_ready_wait", longint'(cfg_ready), 1);
  endtask

  task automatic cfg_write(input int ch, input int mode, input int period, input int duty);
    wait_ready();
    cfg_valid  = 1'b1;
    cfg_ch     = CW'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = N'(period);
    cfg_duty   = N'(duty);
    tick();
    cfg_valid = 1'b0;
    check("ready_drop_after_accept", longint'(cfg_ready), 0);
  endtask

  initial begin
    int first, cnt_out, cnt_wrap, cnt_a, cnt_b, trans, hold_err, acc, acc_mask;
    logic lvl;
    int st_ch [6]     = '{0, 1, 5, 2, 3, 4};
    int st_mode [6]   = '{2, 3, 3, 0, 3, 2};
    int st_period [6] = '{5, 9, 2, 0, 9, 1};
    int st_duty [6]   = '{0, 9, 1, 0, 5, 0};

    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    repeat (4) tick();
    check("reset_out", longint'(out), 0);
    check("reset_wrap", longint'(wrap), 0);
    check("reset_ready", longint'(cfg_ready), 0);

    // Defaults: a pulse every 256 cycles, with all channels aligned.
    reset = 1'b0; en = 1'b1;
    first = 0; cnt_out = 0; cnt_wrap = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i == 1) check("ready_first_cycle", longint'(cfg_ready), 1);
      if (out[0] && first == 0) first = i;
      cnt_out  += int'(out[0]);
      cnt_wrap += int'(wrap[4]);
    end
    check("default_first_pulse", first, 256);
    check("default_pulse_count", cnt_out, 3);
    check("default_wrap_count", cnt_wrap, 3);

    // Channel 1: TOGGLE with period 3. Channel 2: PWM with period 9, duty 3.
    cfg_write(1, 2, 3, 0);
    cfg_write(2, 3, 9, 3);
    repeat (5) tick();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      cnt_a += int'(out[1]);
      cnt_b += int'(out[2]);
    end
    check("toggle_p3_high_of_80", cnt_a, 40);
    check("pwm_p9_d3_high_of_80", cnt_b, 24);

    // Edge values.
    cfg_write(2, 3, 9, 0);
    repeat (3) tick();
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin tick(); cnt_a += int'(out[2]); end
    check("pwm_duty0_const0", cnt_a, 0);
    cfg_write(2, 3, 9, 12);
    repeat (3) tick();
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin tick(); cnt_a += int'(out[2]); end
    check("pwm_duty12_const1", cnt_a, 30);
    cfg_write(3, 1, 0, 0);
    repeat (3) tick();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt_a += int'(out[3]);
      cnt_b += int'(wrap[3]);
    end
    check("pulse_p0_const1", cnt_a, 30);
    check("pulse_p0_wrap_const1", cnt_b, 30);
    cfg_write(1, 2, 0, 0);
    repeat (3) tick();
    trans = 0; lvl = out[1];
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out[1] != lvl) trans++;
      lvl = out[1];
    end
    check("toggle_p0_clk_div2", trans, 30);

    // Gate en while channel 1 is mid-count in TOGGLE mode.
    cfg_write(1, 2, 7, 0);
    repeat (13) tick();
    en = 1'b0;
    lvl = out[1]; hold_err = 0; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out[1] != lvl) hold_err++;
      cnt_a += int'(out[0]);
      cnt_b += int'(|wrap);
    end
    check("toggle_holds_en0", hold_err, 0);
    check("pulse_none_en0", cnt_a, 0);
    check("wrap_none_en0", cnt_b, 0);
    en = 1'b1;
    repeat (40) tick();

    // Hold cfg_valid high for 6 cycles with changing data.
    wait_ready();
    acc = 0; acc_mask = 0;
    for (int j = 0; j < 6; j++) begin
      cfg_valid  = 1'b1;
      cfg_ch     = CW'(st_ch[j]);
      cfg_mode   = 2'(st_mode[j]);
      cfg_period = N'(st_period[j]);
      cfg_duty   = N'(st_duty[j]);
      if (cfg_ready) begin
        acc++;
        acc_mask |= (1 << j);
      end
      tick();
    end
    cfg_valid = 1'b0;
    check("stress_accept_count", acc, 3);
    check("stress_accept_pattern", acc_mask, 21);
    repeat (30) tick();

    // Reset asserted on the accept edge: the write must not be applied.
    wait_ready();
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'd2; cfg_period = '0; cfg_duty = '0;
    reset = 1'b1;
    tick();
    check("midreset_out", longint'(out), 0);
    check("midreset_wrap", longint'(wrap), 0);
    check("midreset_ready", longint'(cfg_ready), 0);
    cfg_valid = 1'b0; reset = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 300; i++) begin tick(); cnt_a += int'(out[1]); end
    check("midreset_default_restored", cnt_a, 1);

    // Reset on the apply edge discards the pending write.
    wait_ready();
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_mode = 2'd1; cfg_period = '0; cfg_duty = '0;
    tick();
    cfg_valid = 1'b0; reset = 1'b1;
    tick();
    check("pending_reset_ready", longint'(cfg_ready), 0);
    reset = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin tick(); cnt_a += int'(out[2]); end
    check("pending_write_discarded", cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
